m14k_ispram_ctl: RTL
====================

Name: m14k_ispram_ctl

Overview:
Instruction scratchpad RAM (ISPRAM) macro controller sitting directly downstream of the icc SPRAM control logic. It consumes ISP_Addr, ISP_RdStr, ISP_DataWrStr, ISP_TagWrStr and ISP_DataTagValue. It returns ISP_DataRdValue, ISP_TagRdValue, ISP_Hit, ISP_Stall and ISP_Present. It owns the data array and the relocatable base tag, and arbitrates a side preload port (boot loader/DMA) against core accesses with starvation-bounded forced stalls.

Parameters:
ISP_ADDR_BITS, 12, word-index width; array depth is 2^ISP_ADDR_BITS x 32 (12 gives 16 KB).
ISP_BASE, 20'h00000, reset value of base PA[31:12].
STARVE_LIMIT, 8, consecutive blocked preload cycles before a forced stall; 0 means never force. Range 0..255.

Ports:
gclk  in  1  clock
gresetn  in  1  synchronous active-low reset
ISP_Addr  in  18  word address [19:2]
ISP_RdStr  in  1  read strobe
ISP_DataWrStr  in  1  data write strobe
ISP_TagWrStr  in  1  base-tag write strobe
ISP_DataTagValue  in  32  write data; bits [31:12] carry the new base on a tag write
ISP_DataRdValue  out  32  read data
ISP_TagRdValue  out  24  {base[31:12], 4'b0000}
ISP_Hit  out  1  read data valid
ISP_Stall  out  1  core access ignored this cycle
ISP_Present  out  1  ISPRAM present
ld_valid  in  1  preload request
ld_addr  in  ISP_ADDR_BITS  preload word index
ld_data  in  32  preload data
ld_ready  out  1  preload accepted when ld_valid & ld_ready
ld_count  out  16  accepted preload words, saturating
isp_oor  out  1  one-cycle pulse on out-of-range core access

Behaviour:
- Reset (gresetn=0 at a gclk edge):
  - Outputs reset to ISP_DataRdValue=0, ISP_Hit=0, ISP_Stall=0, ISP_Present=0, ld_count=0, isp_oor=0.
  - base=ISP_BASE. Starve counter=0. State=RUN.
  - Array contents are not reset.
  - Reset mid-operation aborts any pending forced stall. A preload not yet handshaken is not written.
- ISP_Present: 1 from the first edge after reset deassertion.
- Core access: core_acc = ISP_RdStr | ISP_DataWrStr | ISP_TagWrStr, considered only in state RUN.
- Range check: in range when ISP_Addr[19:ISP_ADDR_BITS+2]==0; otherwise out of range.
- Out-of-range access:
  - Write is dropped.
  - Read returns 0 with ISP_Hit=1.
  - isp_oor=1 on the next cycle.
- Read:
  - Latency 1: strobe sampled at edge N, so ISP_DataRdValue and ISP_Hit are valid after edge N.
  - ISP_Hit is 1 for exactly the cycle following each serviced RdStr.
  - ISP_DataRdValue holds its last value until the next serviced read.
- Write: ISP_DataWrStr writes ISP_DataTagValue at the index on the edge.
- Read and write to the same address in the same cycle: the read returns the new data (write-first bypass).
- ISP_TagWrStr: base <= ISP_DataTagValue[31:12] on the edge. ISP_TagRdValue reflects the new base the following cycle. A tag write may coincide with a data write/read; both take effect.
- Preload arbitration, combinational: ld_ready = (state==RUN & ~core_acc) | state==FORCE.
- Preload transfer: writes ld_data at ld_addr; ld_count increments and saturates at 16'hFFFF.
- Starve counter, 8-bit:
  - +1 each RUN cycle with ld_valid & ~ld_ready, saturating.
  - Cleared on any transfer or when ld_valid=0.
- State machine:
  - RUN -> FORCE when STARVE_LIMIT!=0 and the counter reaches STARVE_LIMIT at an edge.
  - FORCE -> RUN after exactly one cycle, unconditionally; the counter is cleared.
- In FORCE:
  - ISP_Stall=1.
  - All core strobes are ignored: no read, no write, no tag write, ISP_Hit=0 next cycle. The core must re-issue.
  - The preload is accepted if ld_valid. If ld_valid dropped, the cycle is spent idle.
- ISP_Stall is 0 in RUN.
- A preload to the same address as a later core read is visible to that read. Ordering is by edge.

Test Plan:
- Reset: hold gresetn=0 for 2 cycles, release -> all outputs 0 during reset, ISP_Present=1 one edge after release, ISP_TagRdValue={ISP_BASE,4'h0}.
- Write/read: DataWrStr addr 0x00010 data 0xDEADBEEF; RdStr same addr next cycle -> ISP_DataRdValue=0xDEADBEEF with ISP_Hit=1 one cycle after RdStr. Simultaneous write 0x12345678 + read same addr -> read returns 0x12345678.
- Tag: TagWrStr with data 0xBFC01000 -> ISP_TagRdValue=24'hBFC010 next cycle. Concurrent DataWrStr also lands.
- Out of range (ISP_ADDR_BITS=12): ISP_Addr=18'h01000 write then read -> write dropped, read data 0, isp_oor pulses once per access, index 0 unchanged.
- Preload idle: 4 back-to-back ld_valid words with no core traffic -> ld_ready=1 every cycle, ld_count=4, core reads return the loaded data.
- Starvation (STARVE_LIMIT=8): continuous RdStr with ld_valid held -> ld_ready=0 for 8 cycles, then one cycle ISP_Stall=1, ld_ready=1, that cycle's RdStr not serviced (ISP_Hit=0 next cycle), then back to RUN. With STARVE_LIMIT=0 -> never stalls.

Source files
------------

// File: rtl/m14k_ispram_ctl.sv
// ISPRAM macro controller: data array, relocatable base tag, and a side preload
// port arbitrated against core accesses with a bounded-starvation forced stall.
module m14k_ispram_ctl #(
    parameter int          ISP_ADDR_BITS = 12,
    parameter logic [19:0] ISP_BASE      = 20'h00000,
    parameter int          STARVE_LIMIT  = 8
) (
    input  logic                     gclk,
    input  logic                     gresetn,
    input  logic [17:0]              ISP_Addr,
    input  logic                     ISP_RdStr,
    input  logic                     ISP_DataWrStr,
    input  logic                     ISP_TagWrStr,
    input  logic [31:0]              ISP_DataTagValue,
    output logic [31:0]              ISP_DataRdValue,
    output logic [23:0]              ISP_TagRdValue,
    output logic                     ISP_Hit,
    output logic                     ISP_Stall,
    output logic                     ISP_Present,
    input  logic                     ld_valid,
    input  logic [ISP_ADDR_BITS-1:0] ld_addr,
    input  logic [31:0]              ld_data,
    output logic                     ld_ready,
    output logic [15:0]              ld_count,
    output logic                     isp_oor,
    output logic                     dbg_state
);

    // Handshakes: a preload word transfers on an edge where ld_valid & ld_ready
    // are both high; ld_ready is combinational and may drop whenever the core
    // owns the array. Core strobes are single-cycle requests with no ready; in
    // FORCE they are ignored and the core must re-issue.

    typedef enum logic {
        RUN   = 1'b0,
        FORCE = 1'b1
    } state_t;

    localparam int DEPTH = 1 << ISP_ADDR_BITS;

    state_t state_q, state_d;
    logic [7:0]  starve_q, starve_d;
    logic [19:0] base_q;
    logic [31:0] mem [DEPTH];

    logic                     in_run;
    logic                     core_acc;
    logic                     in_range;
    logic [ISP_ADDR_BITS-1:0] core_idx;
    logic                     rd_fire;
    logic                     wr_fire;
    logic                     tag_fire;
    logic                     ld_fire;
    logic                     mem_we;
    logic [ISP_ADDR_BITS-1:0] mem_waddr;
    logic [31:0]              mem_wdata;

    assign in_run   = (state_q == RUN);
    assign core_acc = ISP_RdStr | ISP_DataWrStr | ISP_TagWrStr;
    assign in_range = ((ISP_Addr >> ISP_ADDR_BITS) == 18'd0);
    assign core_idx = ISP_Addr[ISP_ADDR_BITS-1:0];

    assign rd_fire  = in_run & ISP_RdStr;
    assign wr_fire  = in_run & ISP_DataWrStr & in_range;
    assign tag_fire = in_run & ISP_TagWrStr;

    assign ld_ready = (in_run & ~core_acc) | (state_q == FORCE);
    assign ld_fire  = ld_valid & ld_ready;

    // Core writes and preloads never coincide: ld_ready excludes core traffic.
    assign mem_we    = gresetn & (wr_fire | ld_fire);
    assign mem_waddr = wr_fire ? core_idx : ld_addr;
    assign mem_wdata = wr_fire ? ISP_DataTagValue : ld_data;

    assign ISP_Stall      = (state_q == FORCE);
    assign ISP_TagRdValue = {base_q, 4'b0000};
    assign dbg_state      = state_q;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (state_q == RUN) begin
            if (ld_fire || !ld_valid) begin
                starve_d = 8'd0;
            end else if (starve_q != 8'hFF) begin
                starve_d = starve_q + 8'd1;
            end
            if (STARVE_LIMIT != 0 && starve_d == 8'(STARVE_LIMIT)) begin
                state_d = FORCE;
            end
        end else begin
            state_d  = RUN;
            starve_d = 8'd0;
        end
    end

    always_ff @(posedge gclk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge gclk) begin
        if (!gresetn) begin
            state_q         <= RUN;
            starve_q        <= 8'd0;
            base_q          <= ISP_BASE;
            ISP_DataRdValue <= 32'd0;
            ISP_Hit         <= 1'b0;
            ISP_Present     <= 1'b0;
            ld_count        <= 16'd0;
            isp_oor         <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            ISP_Present <= 1'b1;
            ISP_Hit     <= rd_fire;
            isp_oor     <= in_run & core_acc & ~in_range;
            if (tag_fire) begin
                base_q <= ISP_DataTagValue[31:12];
            end
            // Write-first: a same-cycle data write is what the read returns.
            if (rd_fire) begin
                if (!in_range) begin
                    ISP_DataRdValue <= 32'd0;
                end else if (ISP_DataWrStr) begin
                    ISP_DataRdValue <= ISP_DataTagValue;
                end else begin
                    ISP_DataRdValue <= mem[core_idx];
                end
            end
            if (ld_fire && ld_count != 16'hFFFF) begin
                ld_count <= ld_count + 16'd1;
            end
        end
    end

endmodule
